sobel_bbox_detect: RTL
======================

Name: sobel_bbox_detect

Overview:
- Downstream consumer of the 1-bit Sobel edge stream (HS, VS, DE, edge bit) produced by the VGA sobel image path.
- Per frame, tracks the bounding box of all edge pixels (min/max X/Y) and counts edge pixels.
- Latches results at end of frame with a one-cycle done pulse, for the overlay/tracking logic.
- Runs entirely in the VGA pixel clock domain.

Parameters:
- H_ACTIVE, 640, active pixels per line; DE-qualified pixels at X >= H_ACTIVE are ignored.
- V_ACTIVE, 480, active lines per frame; lines at Y >= V_ACTIVE are ignored.
- COORD_W, 12, coordinate width, matching the VGA controller's Coord_X/Coord_Y.
- CNT_W, 20, edge-pixel counter width; counter saturates at all-ones.
- SYNC_POL, 0, active level of i_hs/i_vs (0 = active-low, standard VGA).

Ports:
- vga_clk  in  1  pixel clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_hs  in  1  horizontal sync; polarity set by SYNC_POL.
- i_vs  in  1  vertical sync; polarity set by SYNC_POL.
- i_de  in  1  active-video qualifier.
- i_sobel_data  in  1  edge bit, valid when i_de=1.
- o_min_x  out  COORD_W  leftmost edge column of the last complete frame.
- o_max_x  out  COORD_W  rightmost edge column.
- o_min_y  out  COORD_W  topmost edge row.
- o_max_y  out  COORD_W  bottommost edge row.
- o_edge_cnt  out  CNT_W  edge pixels counted in the last complete frame (saturating).
- o_box_valid  out  1  last complete frame contained at least one counted edge pixel.
- o_frame_done  out  1  one-cycle pulse when the outputs above update.

Behaviour:
- Reset (rst_n=0 sampled at the clock edge):
  - All outputs go to 0 and the FSM goes to WAIT_VS.
  - Accumulators are cleared.
  - No o_frame_done is generated for the frame in progress.
- VS edge detect: vs_d is a registered copy of i_vs. A frame boundary (fb) is the cycle where i_vs is at the active level and vs_d is not.
- X counter:
  - Increments on each i_de=1 cycle.
  - Clears on the cycle after a DE falling edge and on fb.
- Y counter:
  - Increments once per DE falling edge.
  - Clears on fb.
- FSM states:
  - WAIT_VS: ignore all pixels until fb, then go to ACTIVE with accumulators initialised.
    - min_x/min_y init to all-ones; max_x/max_y init to 0; count init to 0.
  - ACTIVE: accumulate pixels. On fb, go to LATCH.
  - LATCH: single cycle. Then return to ACTIVE with accumulators re-initialised.
- Accumulation: a qualifying pixel requires i_de=1, i_sobel_data=1, X < H_ACTIVE and Y < V_ACTIVE. For each one:
  - min/max registers update by compare.
  - Count increments, saturating at 2^CNT_W-1.
- Latch (cycle after fb):
  - If count > 0: o_min/max_* take the accumulated values and o_box_valid=1.
  - If count = 0: o_min/max_* = 0 and o_box_valid=0.
  - o_edge_cnt takes count.
  - o_frame_done=1 for exactly this cycle.
  - Latency: o_frame_done is high 2 clocks after i_vs first reaches the active level.
- Simultaneous events:
  - If fb and a qualifying pixel occur in the same cycle, the pixel is discarded.
  - fb takes precedence over all accumulation.
- i_hs is used only to re-arm the X counter when DE glitches. X also clears on the HS active edge.
- Outputs hold their values between frames. No handshake; consumers sample on o_frame_done.

Optional Feature:
- SOBEL_BBOX_NOISE_FILTER_EN
  - Defined: a pixel qualifies only if the previous DE-qualified pixel on the same line was also an edge (horizontal run >= 2). The first pixel of a run is never counted; isolated single pixels are rejected.
    - The run flag clears on DE falling edge and on fb.
  - Undefined: every edge pixel qualifies; no extra register.

Decomposition:
- Shared package sobel_pkg holds:
  - COORD_W and the default H_ACTIVE/V_ACTIVE constants (shared with the VGA controller and sobel generator).
  - State encoding: WAIT_VS, ACTIVE, LATCH.
- One natural sub-module: vga_sync_counter. It takes i_hs/i_vs/i_de and produces X, Y and fb; it is reusable by other stream consumers.
- Bbox/count accumulation stays in the top.

Test Plan (H_ACTIVE=30, V_ACTIVE=30, filter off unless noted):
1. Full frame of zeros, then VS -> o_frame_done pulse 2 clocks after VS active; o_box_valid=0; all box outputs 0; o_edge_cnt=0.
2. Single edge pixel at (5,7) -> o_min_x=o_max_x=5; o_min_y=o_max_y=7; o_edge_cnt=1; o_box_valid=1.
3. All-ones frame -> box (0,0)-(29,29); o_edge_cnt=900.
4. DE held 34 cycles per line with edge=1 on cycles 30-33 only -> o_edge_cnt=0; o_box_valid=0 (beyond-H_ACTIVE pixels ignored).
5. rst_n low for 2 cycles mid-frame -> outputs 0. No o_frame_done at the next VS (WAIT_VS). The frame after that reports correctly.
6. SOBEL_BBOX_NOISE_FILTER_EN defined; isolated pixel at (3,3) plus run of 4 at x=10..13, y=20 -> o_edge_cnt=3; box (11,20)-(13,20).

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: constants shared by the VGA controller, the Sobel generator and
// the stream consumers, plus the state encoding of the bounding-box detector.
//   COORD_W          width of Coord_X/Coord_Y style pixel coordinates
//   H_ACTIVE/V_ACTIVE default active-area size (640x480)
//   bbox_state_e     WAIT_VS / ACTIVE / LATCH
package sobel_pkg;

  localparam int unsigned COORD_W  = 12;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    LATCH   = 2'd2
  } bbox_state_e;

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: derives pixel coordinates and a frame-boundary strobe from
// a VGA-style HS/VS/DE stream. Reusable by any stream consumer.
// Ports:
//   vga_clk, rst_n  pixel clock, synchronous active-low reset
//   hs_i, vs_i      syncs, active level given by SYNC_POL
//   de_i            active-video qualifier
//   x_o             column of the pixel presented this cycle
//   y_o             line index (increments on each DE falling edge)
//   fb_o            frame boundary: VS at active level, registered VS not
module vga_sync_counter #(
  parameter int unsigned COORD_W  = sobel_pkg::COORD_W,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               hs_i,
  input  logic               vs_i,
  input  logic               de_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               fb_o
);
  import sobel_pkg::*;

  logic               vs_q, hs_q, de_q;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               hs_edge, de_fall;

  assign fb_o    = (vs_i == SYNC_POL) && (vs_q != SYNC_POL);
  assign hs_edge = (hs_i == SYNC_POL) && (hs_q != SYNC_POL);
  assign de_fall = de_q & ~de_i;

  // Counters stick at all-ones so an over-long line/frame can never wrap
  // back into the active window.
  always_comb begin
    x_d = x_q;
    if (fb_o || de_fall || hs_edge) begin
      x_d = '0;
    end else if (de_i && (x_q != '1)) begin
      x_d = x_q + 1'b1;
    end

    y_d = y_q;
    if (fb_o) begin
      y_d = '0;
    end else if (de_fall && (y_q != '1)) begin
      y_d = y_q + 1'b1;
    end
  end

  // Syncs reset to the active level so that leaving reset while VS is
  // asserted does not produce a spurious frame boundary.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      vs_q <= SYNC_POL;
      hs_q <= SYNC_POL;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      vs_q <= vs_i;
      hs_q <= hs_i;
      de_q <= de_i;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/sobel_bbox_detect.sv
// sobel_bbox_detect: per-frame bounding box and edge-pixel count of the 1-bit
// Sobel edge stream. Results latch at end of frame with a one-cycle
// o_frame_done pulse and hold until the next frame completes.
// Ports:
//   vga_clk, rst_n            pixel clock, synchronous active-low reset
//   i_hs, i_vs, i_de          VGA timing (sync polarity from SYNC_POL)
//   i_sobel_data              edge bit, valid while i_de=1
//   o_min_x/o_max_x           column extent of edges in last complete frame
//   o_min_y/o_max_y           row extent of edges in last complete frame
//   o_edge_cnt                saturating edge-pixel count
//   o_box_valid               last frame had at least one counted pixel
//   o_frame_done              one-cycle pulse when the outputs update
// Build option: define SOBEL_BBOX_NOISE_FILTER_EN to count only pixels whose
// preceding DE-qualified pixel on the same line was also an edge.
module sobel_bbox_detect #(
  parameter int unsigned H_ACTIVE = sobel_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = sobel_pkg::V_ACTIVE,
  parameter int unsigned COORD_W  = sobel_pkg::COORD_W,
  parameter int unsigned CNT_W    = 20,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               i_hs,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic               i_sobel_data,
  output logic [COORD_W-1:0] o_min_x,
  output logic [COORD_W-1:0] o_max_x,
  output logic [COORD_W-1:0] o_min_y,
  output logic [COORD_W-1:0] o_max_y,
  output logic [CNT_W-1:0]   o_edge_cnt,
  output logic               o_box_valid,
  output logic               o_frame_done
);
  import sobel_pkg::*;

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_ACTIVE);

  logic [COORD_W-1:0] x, y;
  logic               fb;

  vga_sync_counter #(
    .COORD_W  (COORD_W),
    .SYNC_POL (SYNC_POL)
  ) u_sync (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .hs_i    (i_hs),
    .vs_i    (i_vs),
    .de_i    (i_de),
    .x_o     (x),
    .y_o     (y),
    .fb_o    (fb)
  );

  logic edge_ok, pix_ok;

`ifdef SOBEL_BBOX_NOISE_FILTER_EN
  logic run_q, run_d;
  // The flag is only consulted on DE-high cycles, so clearing it on every
  // DE-low cycle is equivalent to clearing it on the DE falling edge.
  always_comb begin
    run_d = ~fb & i_de & i_sobel_data;
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run_d;
    end
  end

  assign edge_ok = i_sobel_data & run_q;
`else
  assign edge_ok = i_sobel_data;
`endif

  assign pix_ok = i_de & edge_ok & (x < X_LIM) & (y < Y_LIM);

  bbox_state_e        state_q, state_d;
  logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [COORD_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] out_min_x_q, out_min_x_d, out_max_x_q, out_max_x_d;
  logic [COORD_W-1:0] out_min_y_q, out_min_y_d, out_max_y_q, out_max_y_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               valid_q, valid_d, done_q, done_d;

  always_comb begin
    state_d     = state_q;
    min_x_d     = min_x_q;
    max_x_d     = max_x_q;
    min_y_d     = min_y_q;
    max_y_d     = max_y_q;
    cnt_d       = cnt_q;
    out_min_x_d = out_min_x_q;
    out_max_x_d = out_max_x_q;
    out_min_y_d = out_min_y_q;
    out_max_y_d = out_max_y_q;
    out_cnt_d   = out_cnt_q;
    valid_d     = valid_q;
    done_d      = 1'b0;

    unique case (state_q)
      WAIT_VS: begin
        if (fb) begin
          state_d = ACTIVE;
          min_x_d = '1;
          max_x_d = '0;
          min_y_d = '1;
          max_y_d = '0;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        // A pixel coinciding with the frame boundary is dropped.
        if (fb) begin
          state_d = LATCH;
        end else if (pix_ok) begin
          if (x < min_x_q) min_x_d = x;
          if (x > max_x_q) max_x_d = x;
          if (y < min_y_q) min_y_d = y;
          if (y > max_y_q) max_y_d = y;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        state_d   = ACTIVE;
        done_d    = 1'b1;
        out_cnt_d = cnt_q;
        if (cnt_q != '0) begin
          out_min_x_d = min_x_q;
          out_max_x_d = max_x_q;
          out_min_y_d = min_y_q;
          out_max_y_d = max_y_q;
          valid_d     = 1'b1;
        end else begin
          out_min_x_d = '0;
          out_max_x_d = '0;
          out_min_y_d = '0;
          out_max_y_d = '0;
          valid_d     = 1'b0;
        end
        min_x_d = '1;
        max_x_d = '0;
        min_y_d = '1;
        max_y_d = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = WAIT_VS;
      end
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_VS;
      min_x_q     <= '0;
      max_x_q     <= '0;
      min_y_q     <= '0;
      max_y_q     <= '0;
      cnt_q       <= '0;
      out_min_x_q <= '0;
      out_max_x_q <= '0;
      out_min_y_q <= '0;
      out_max_y_q <= '0;
      out_cnt_q   <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_x_q     <= min_x_d;
      max_x_q     <= max_x_d;
      min_y_q     <= min_y_d;
      max_y_q     <= max_y_d;
      cnt_q       <= cnt_d;
      out_min_x_q <= out_min_x_d;
      out_max_x_q <= out_max_x_d;
      out_min_y_q <= out_min_y_d;
      out_max_y_q <= out_max_y_d;
      out_cnt_q   <= out_cnt_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign o_min_x      = out_min_x_q;
  assign o_max_x      = out_max_x_q;
  assign o_min_y      = out_min_y_q;
  assign o_max_y      = out_max_y_q;
  assign o_edge_cnt   = out_cnt_q;
  assign o_box_valid  = valid_q;
  assign o_frame_done = done_q;

endmodule
